// File: rtl/idea_pkg.sv
// Shared definitions for the iDEA-style soft core: opcodes, instruction field
// positions, ALU operation codes, pipeline depth and the default boot program.
// No ports; imported by idea_alu and idea_cpu_core.
package idea_pkg;

    localparam int N_STAGES   = 9;   // IF1 IF2 IF3 ID EX1 EX2 EX3 EX4 WB
    localparam int PROG_WORDS = 16;  // ROM words that the program image covers

    // MIPS I-type opcodes handled by this core
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // I-type field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SLT,
        ALU_SLTU,
        ALU_LUI,
        ALU_NOP
    } alu_op_t;

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Anything not recognised, including the all-zero word, decodes to NOP.
    function automatic alu_op_t decode_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU: return ALU_ADD;
            OP_SLTI:           return ALU_SLT;
            OP_SLTIU:          return ALU_SLTU;
            OP_LUI:            return ALU_LUI;
            default:           return ALU_NOP;
        endcase
    endfunction

    // Word 0 sits in the least significant 32 bits.
    localparam logic [PROG_WORDS*32-1:0] DEFAULT_PROG = {
        {(8*32){1'b0}},
        i_type(OP_ADDI,  5'd31, 5'd22, 16'd26),
        i_type(OP_SLTIU, 5'd0,  5'd25, 16'd0),
        i_type(OP_SLTI,  5'd0,  5'd26, 16'd5),
        i_type(OP_ADDI,  5'd0,  5'd27, 16'd11),
        i_type(OP_LUI,   5'd0,  5'd28, 16'h0008),
        i_type(OP_ADDI,  5'd0,  5'd29, 16'd4),
        i_type(OP_ADDIU, 5'd0,  5'd30, 16'd7),
        i_type(OP_ADDI,  5'd0,  5'd31, 16'd3)
    };

endpackage

// File: rtl/idea_alu.sv
// Combinational DSP-style add/compare unit: one adder serves ADD and, with the
// second operand inverted plus carry-in, the subtract used by SLT/SLTU.
// Ports: op (operation), a/b (operands, b already sign-extended), y (result).
module idea_alu
    import idea_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic            sub;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum_ext;
    logic            lt_s;
    logic            lt_u;

    always_comb begin
        sub     = (op == ALU_SLT) || (op == ALU_SLTU);
        b_eff   = sub ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
        // Signs differ: a is smaller exactly when a is negative; otherwise
        // the sign of a-b decides (no overflow possible in that case).
        lt_s    = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : sum_ext[XLEN-1];
        // a - b borrows (no carry out) exactly when a < b unsigned.
        lt_u    = ~sum_ext[XLEN];

        case (op)
            ALU_ADD:  y = sum_ext[XLEN-1:0];
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
            ALU_LUI:  y = {b[15:0], {(XLEN-16){1'b0}}};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/idea_cpu_core.sv
// Top of the 9-stage in-order iDEA-style core (IF1 IF2 IF3 ID EX1-4 WB) with
// internal ROM and 32x32 write-first register file; no stalls, no forwarding.
// Ports: clk, rst (sync active-low), dummy, trace_we/trace_rd_addr/trace_rd_data.
module idea_cpu_core
    import idea_pkg::*;
#(
    parameter int                        IMEM_DEPTH = 64,
    parameter int                        XLEN       = 32,
    parameter logic [PROG_WORDS*32-1:0]  ROM_INIT   = DEFAULT_PROG
) (
    input  logic            clk,
    input  logic            rst,
    output logic            dummy,
    output logic            trace_we,
    output logic [4:0]      trace_rd_addr,
    output logic [XLEN-1:0] trace_rd_data
);

    localparam int PC_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    // Instruction ROM, fixed at elaboration; words past the image read as 0 (NOP).
    logic [31:0] rom [IMEM_DEPTH];
    for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
        if (i < PROG_WORDS) begin : g_img
            assign rom[i] = ROM_INIT[i*32 +: 32];
        end else begin : g_zero
            assign rom[i] = '0;
        end
    end

    // Fetch stages
    logic [PC_W-1:0] pc;
    logic            if2_vld;
    logic [PC_W-1:0] if2_pc;
    logic            if3_vld;
    logic [31:0]     if3_ir;
    logic            id_vld;
    logic [31:0]     id_ir;

    // Execute / writeback stages
    logic            ex1_we;
    alu_op_t         ex1_op;
    logic [4:0]      ex1_rd;
    logic [XLEN-1:0] ex1_a;
    logic [XLEN-1:0] ex1_b;
    logic            ex2_we, ex3_we, ex4_we, wb_we;
    logic [4:0]      ex2_rd, ex3_rd, ex4_rd, wb_rd;
    logic [XLEN-1:0] ex2_res, ex3_res, ex4_res, wb_data;

    logic [XLEN-1:0] regs [32];

    // ID decode and register read
    logic [5:0]      id_opc;
    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [15:0]     id_imm;
    alu_op_t         id_op;
    logic            id_we;
    logic [XLEN-1:0] id_a;
    logic [XLEN-1:0] id_b;
    logic [XLEN-1:0] alu_y;

    always_comb begin
        id_opc = id_ir[OPC_MSB:OPC_LSB];
        id_rs  = id_ir[RS_MSB:RS_LSB];
        id_rt  = id_ir[RT_MSB:RT_LSB];
        id_imm = id_ir[IMM_MSB:IMM_LSB];
        id_op  = decode_op(id_opc);
        // r0 writes are squashed here so they never reach WB or the trace.
        id_we  = id_vld && (id_op != ALU_NOP) && (id_rt != 5'd0);
        id_b   = {{(XLEN-16){id_imm[15]}}, id_imm};
        // Write-first: a WB write in this same cycle is visible to ID.
        if (id_rs == 5'd0) begin
            id_a = '0;
        end else if (wb_we && (wb_rd == id_rs)) begin
            id_a = wb_data;
        end else begin
            id_a = regs[id_rs];
        end
    end

    idea_alu #(.XLEN(XLEN)) u_alu (
        .op (ex1_op),
        .a  (ex1_a),
        .b  (ex1_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= '0;
            if2_vld <= 1'b0;
            if2_pc  <= '0;
            if3_vld <= 1'b0;
            if3_ir  <= '0;
            id_vld  <= 1'b0;
            id_ir   <= '0;
            ex1_we  <= 1'b0;
            ex1_op  <= ALU_NOP;
            ex1_rd  <= '0;
            ex1_a   <= '0;
            ex1_b   <= '0;
            ex2_we  <= 1'b0;
            ex2_rd  <= '0;
            ex2_res <= '0;
            ex3_we  <= 1'b0;
            ex3_rd  <= '0;
            ex3_res <= '0;
            ex4_we  <= 1'b0;
            ex4_rd  <= '0;
            ex4_res <= '0;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            dummy   <= 1'b0;
        end else begin
            pc      <= (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + 1'b1;
            // IF1 -> IF2: every cycle out of reset fetches a valid word.
            if2_vld <= 1'b1;
            if2_pc  <= pc;
            // IF2 -> IF3: ROM access
            if3_vld <= if2_vld;
            if3_ir  <= rom[if2_pc];
            // IF3 -> ID
            id_vld  <= if3_vld;
            id_ir   <= if3_ir;
            // ID -> EX1
            ex1_we  <= id_we;
            ex1_op  <= id_op;
            ex1_rd  <= id_rt;
            ex1_a   <= id_a;
            ex1_b   <= id_b;
            // EX1 computes; EX2..EX4 model the remaining DSP pipeline depth.
            ex2_we  <= ex1_we;
            ex2_rd  <= ex1_rd;
            ex2_res <= alu_y;
            ex3_we  <= ex2_we;
            ex3_rd  <= ex2_rd;
            ex3_res <= ex2_res;
            ex4_we  <= ex3_we;
            ex4_rd  <= ex3_rd;
            ex4_res <= ex3_res;
            wb_we   <= ex4_we;
            wb_rd   <= ex4_rd;
            wb_data <= ex4_res;
            if (wb_we) begin
                dummy <= wb_data[0];
            end
        end
    end

    // Register file; regs[0] is never written because wb_we excludes r0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign trace_we      = wb_we;
    assign trace_rd_addr = wb_rd;
    assign trace_rd_data = wb_data;

endmodule

// File: tb/tb_idea_cpu_core.sv
module tb_idea_cpu_core;
    import idea_pkg::*;

    // Second program: signed/unsigned compares, hazard distance, r0 writes,
    // an unknown opcode, and a large negative compare.
    localparam logic [PROG_WORDS*32-1:0] PROG_B = {
        i_type(OP_SLTI,  5'd9, 5'd10, 16'h7FFF),   // 15
        {(4*32){1'b0}},                            // 11..14 NOP
        i_type(OP_LUI,   5'd0, 5'd9,  16'h8000),   // 10
        i_type(OP_ADDIU, 5'd5, 5'd8,  16'h0010),   // 9
        i_type(OP_ADDI,  5'd0, 5'd6,  16'h0000),   // 8
        i_type(OP_SLTIU, 5'd1, 5'd3,  16'hFFFF),   // 7
        i_type(OP_ADDI,  5'd4, 5'd7,  16'h0001),   // 6
        i_type(OP_SLTI,  5'd1, 5'd2,  16'h0000),   // 5
        i_type(6'h3F,    5'd0, 5'd11, 16'h1234),   // 4 unknown opcode
        i_type(OP_ADDI,  5'd0, 5'd0,  16'h0005),   // 3 write to r0
        i_type(OP_ADDI,  5'd4, 5'd5,  16'h0001),   // 2 adjacent consumer
        i_type(OP_ADDI,  5'd0, 5'd4,  16'h0009),   // 1
        i_type(OP_ADDI,  5'd0, 5'd1,  16'hFFFF)    // 0
    };

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic        dummy_a, dummy_b;
    logic        trace_we_a, trace_we_b;
    logic [4:0]  trace_rd_addr_a, trace_rd_addr_b;
    logic [31:0] trace_rd_data_a, trace_rd_data_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_a = -1;
    int   first_b = -1;
    int   idx_a = 0;
    int   idx_b = 0;
    int   rel;

    idea_cpu_core #(.IMEM_DEPTH(64), .XLEN(32)) dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .dummy         (dummy_a),
        .trace_we      (trace_we_a),
        .trace_rd_addr (trace_rd_addr_a),
        .trace_rd_data (trace_rd_data_a)
    );

    idea_cpu_core #(.IMEM_DEPTH(64), .XLEN(32), .ROM_INIT(PROG_B)) dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .dummy         (dummy_b),
        .trace_we      (trace_we_b),
        .trace_rd_addr (trace_rd_addr_b),
        .trace_rd_data (trace_rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_a();
        qa.push_back('{5'd31, 32'd3});
        qa.push_back('{5'd30, 32'd7});
        qa.push_back('{5'd29, 32'd4});
        qa.push_back('{5'd28, 32'h0008_0000});
        qa.push_back('{5'd27, 32'h0000_000B});
        qa.push_back('{5'd26, 32'd1});
        qa.push_back('{5'd25, 32'd0});
        qa.push_back('{5'd22, 32'h0000_001D});
    endtask

    task automatic push_b();
        qb.push_back('{5'd1,  32'hFFFF_FFFF});
        qb.push_back('{5'd4,  32'd9});
        qb.push_back('{5'd5,  32'd1});          // stale read of r4
        qb.push_back('{5'd2,  32'd1});          // -1 < 0 signed
        qb.push_back('{5'd7,  32'd10});         // distance 5: sees r4=9
        qb.push_back('{5'd3,  32'd0});          // 0xFFFFFFFF < 0xFFFFFFFF unsigned
        qb.push_back('{5'd6,  32'd0});          // r0 still reads 0
        qb.push_back('{5'd8,  32'h0000_0011});
        qb.push_back('{5'd9,  32'h8000_0000});
        qb.push_back('{5'd10, 32'd1});          // 0x80000000 < 0x7FFF signed
    endtask

    // Monitors: compare each trace write against the head of its queue.
    always @(negedge clk) begin
        if (trace_we_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trace_a_unexpected: got rd=%0d data=0x%08h, expected no write",
                         trace_rd_addr_a, trace_rd_data_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (first_a < 0) first_a = cyc;
                check($sformatf("trace_a[%0d].rd", idx_a), {27'd0, trace_rd_addr_a}, {27'd0, e.rd});
                check($sformatf("trace_a[%0d].data", idx_a), trace_rd_data_a, e.data);
                idx_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (trace_we_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL trace_b_unexpected: got rd=%0d data=0x%08h, expected no write",
                         trace_rd_addr_b, trace_rd_data_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (first_b < 0) first_b = cyc;
                check($sformatf("trace_b[%0d].rd", idx_b), {27'd0, trace_rd_addr_b}, {27'd0, e.rd});
                check($sformatf("trace_b[%0d].data", idx_b), trace_rd_data_b, e.data);
                idx_b++;
            end
        end
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_we_a",    {31'd0, trace_we_a}, 32'd0);
        check("reset_addr_a",  {27'd0, trace_rd_addr_a}, 32'd0);
        check("reset_data_a",  trace_rd_data_a, 32'd0);
        check("reset_dummy_a", {31'd0, dummy_a}, 32'd0);
        check("reset_we_b",    {31'd0, trace_we_b}, 32'd0);
        check("reset_addr_b",  {27'd0, trace_rd_addr_b}, 32'd0);
        check("reset_data_b",  trace_rd_data_b, 32'd0);
        check("reset_dummy_b", {31'd0, dummy_b}, 32'd0);

        // Default program from a clean reset.
        push_a();
        idx_a = 0;
        first_a = -1;
        rel = cyc;
        rst_a = 1'b1;
        repeat (50) @(negedge clk);
        check("a_run1_missing", qa.size(), 32'd0);
        check("a_run1_latency", first_a - rel, 32'd8);
        check("a_run1_dummy", {31'd0, dummy_a}, 32'd1);

        // Reset again, release, then reset 4 cycles into the run.
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midreset_we_%0d", i), {31'd0, trace_we_a}, 32'd0);
        end
        check("midreset_dummy", {31'd0, dummy_a}, 32'd0);
        push_a();
        idx_a = 0;
        first_a = -1;
        rel = cyc;
        rst_a = 1'b1;
        repeat (50) @(negedge clk);
        check("a_run2_missing", qa.size(), 32'd0);
        check("a_run2_latency", first_a - rel, 32'd8);
        rst_a = 1'b0;

        // Compare / hazard / r0 / unknown-opcode program.
        push_b();
        idx_b = 0;
        first_b = -1;
        rel = cyc;
        rst_b = 1'b1;
        repeat (40) @(negedge clk);
        check("b_missing", qb.size(), 32'd0);
        check("b_latency", first_b - rel, 32'd8);
        check("b_dummy", {31'd0, dummy_b}, 32'd1);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idea_cpu_core.md
Name: idea_cpu_core

Overview:
- iDEA-style scalar soft-core processor; integer arithmetic is done in a DSP48E1-style execution unit.
- This block is the top of the processor. It has a 9-stage in-order pipeline (IF1 IF2 IF3 ID EX1 EX2 EX3 EX4 WB), an internal instruction ROM and a 32x32 register file.
- Scope of this revision: MIPS-encoded immediate arithmetic instructions only.
- A writeback trace port exposes every architectural register write for checking.

Parameters:
- IMEM_DEPTH, 64, instruction ROM words; PC wraps modulo depth.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- dummy  out  1  registered bit 0 of the last register-write data; 0 after reset.
- trace_we  out  1  high for the WB cycle of an instruction writing a register other than r0.
- trace_rd_addr  out  5  destination register of that write.
- trace_rd_data  out  32  value written.

Behaviour:
- Reset (rst=0 at a clk edge):
  - PC is set to 0.
  - All pipeline valid bits are cleared.
  - All 32 registers are set to 0.
  - trace_we=0, trace_rd_addr=0, trace_rd_data=0, dummy=0.
  - Reset mid-operation discards every in-flight instruction.
- Fetch:
  - The first cycle with rst=1 fetches PC=0; PC then increments by 1 word per cycle.
  - There are no stalls and no branches.
  - The ROM is read-only. Its contents are set at elaboration; unused words are 0.
- Instruction format: MIPS I-type, opcode[31:26], rs[25:21], rt[20:16], imm[15:0]; rt is the destination.
- Opcodes:
  - 0x08 ADDI: rs + sext(imm); no overflow trap.
  - 0x09 ADDIU: identical to ADDI.
  - 0x0A SLTI: (signed rs < sext(imm)) ? 1 : 0.
  - 0x0B SLTIU: (unsigned rs < unsigned sext(imm)) ? 1 : 0.
  - 0x0F LUI: {imm, 16'h0}.
  - Any other opcode, including all-zero, is a NOP with no write.
- Timing:
  - Instruction k (fetched in cycle k after reset release) reads rs combinationally in ID, cycle k+3.
  - The result moves through EX1-EX4 and is written in WB, cycle k+8. The register write takes effect at the end of that cycle.
  - trace_* outputs are valid during cycle k+8.
- Hazards:
  - The register file is write-first: a read of the register written in the same cycle returns the new value.
  - There is no forwarding and no interlock. A consumer must be 5 or more instructions after its producer; closer consumers read the stale value (defined behaviour, not an error).
- r0 always reads 0. Writes to r0 are dropped and do not raise trace_we.
- Default program (ROM words 0..7, rest 0):
  - 0: ADDI r31,r0,3
  - 1: ADDIU r30,r0,7
  - 2: ADDI r29,r0,4
  - 3: LUI r28,0x0008
  - 4: ADDI r27,r0,11
  - 5: SLTI r26,r0,5
  - 6: SLTIU r25,r0,0
  - 7: ADDI r22,r31,26
- Required trace sequence, in order: (31,3) (30,7) (29,4) (28,0x00080000) (27,0xB) (26,1) (25,0) (22,0x1D). No further trace writes follow.

Decomposition:
- Package idea_pkg:
  - opcode constants (OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI);
  - ALU-operation enum (ADD, SLT, SLTU, LUI, NOP);
  - field-position constants;
  - stage count (9).
- One sub-module, idea_alu: a combinational DSP-style add/compare unit.
- The 4 EX pipeline registers stay in the top-level block.

Test Plan:
- Default program:
  - Hold rst=0 for 5 cycles, then release and run 50 cycles.
  - The trace shows exactly the 8-entry sequence above, in order.
  - The first trace_we occurs 8 cycles after the first fetch.
- Reset mid-run:
  - Assert rst=0 on cycle 4 after release, then release again.
  - No trace_we is asserted during reset.
  - The full 8-entry sequence restarts from r31=3; it is not partially repeated.
- Sign and unsigned compare:
  - ROM: ADDI r1,r0,-1; five NOPs; SLTI r2,r1,0; SLTIU r3,r1,0xFFFF.
  - Required: r1=0xFFFFFFFF, r2=1, r3=0.
- Hazard distance:
  - ROM: ADDI r4,r0,9; ADDI r5,r4,1 (adjacent).
  - Required: r5=1 (stale read).
  - With four NOPs between the two instructions: r5=10.
- r0 protection:
  - ROM: ADDI r0,r0,5; five NOPs; ADDI r6,r0,0.
  - Required: no trace for r0; r6=0.
- Unknown opcode: opcode 0x3F produces no trace_we, and the following instructions are unaffected.
